// File: rtl/usb_pkg.sv
// Line-state and receiver-state types shared by the USB full-speed transmitter and receiver.
package usb_pkg;

    typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, DONE, ERROR} rx_state_t;

    localparam logic [7:0] SYNC_BITS   = 8'b1000_0000;
    localparam int         STUFF_LIMIT = 6;

    function automatic line_state_t decode_line(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   return J;
            2'b01:   return K;
            2'b00:   return SE0;
            default: return SE1;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Synchronizes D+/D-, resyncs the bit phase on every D+ edge and strobes mid-bit samples.
module usb_rx_bit_timer
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_plus,
    input  logic        d_minus,
    output line_state_t line,
    output logic        sample,
    output logic        jk_edge
);

    localparam int PW = $clog2(CLKS_PER_BIT);

    logic [1:0]    dp_sync;
    logic [1:0]    dm_sync;
    logic          dp_prev;
    logic          dm_prev;
    logic [PW-1:0] phase;
    line_state_t   line_prev;

    // Synchronizers reset to J so leaving reset never fakes a J->K edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_sync <= 2'b11;
            dm_sync <= 2'b00;
            dp_prev <= 1'b1;
            dm_prev <= 1'b0;
            phase   <= '0;
        end else begin
            dp_sync <= {dp_sync[0], d_plus};
            dm_sync <= {dm_sync[0], d_minus};
            dp_prev <= dp_sync[1];
            dm_prev <= dm_sync[1];
            if (dp_sync[1] != dp_prev)
                phase <= '0;
            else if (phase == PW'(CLKS_PER_BIT - 1))
                phase <= '0;
            else
                phase <= phase + PW'(1);
        end
    end

    always_comb begin
        line      = decode_line(dp_sync[1], dm_sync[1]);
        line_prev = decode_line(dp_prev, dm_prev);
        sample    = (phase == PW'(SAMPLE_POINT));
        jk_edge   = (line_prev == J) && (line == K);
    end

endmodule

// File: rtl/usb_receiver.sv
// USB full-speed packet receiver: NRZI decode, bit unstuffing, SYNC/EOP framing, 64-bit payload capture.
//  state | meaning
//  IDLE  | bus idle, waiting for the first J->K edge of SYNC
//  SYNC  | collecting the 8 SYNC bits
//  DATA  | shifting in unstuffed payload bits
//  EOP   | expecting the second SE0, then J
//  DONE  | one cycle, payload published
//  ERROR | packet aborted, waiting for IDLE_BITS consecutive J samples
module usb_receiver
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int DATA_BITS    = 64,
    parameter int IDLE_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_plus,
    input  logic                 d_minus,
    output logic [DATA_BITS-1:0] rcv_data,
    output logic                 rcv_data_valid,
    output logic                 rcv_error,
    output logic                 receiving
);

    line_state_t          line;
    logic                 sample;
    logic                 jk_edge;
    rx_state_t            state;
    line_state_t          nrzi_ref;
    logic [2:0]           ones;
    logic [6:0]           cnt;
    logic                 eop_stage;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shifted;
    logic                 sym_ok;
    logic                 bit_val;
    logic                 stuff_drop;
    logic                 stuff_err;
    logic                 fail;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_POINT(SAMPLE_POINT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .d_plus (d_plus),
        .d_minus(d_minus),
        .line   (line),
        .sample (sample),
        .jk_edge(jk_edge)
    );

    // The ones run starts counting in SYNC, so its trailing 1 counts toward a stuff.
    always_comb begin
        sym_ok     = (line == J) || (line == K);
        bit_val    = (line == nrzi_ref);
        stuff_drop = sym_ok && (ones == 3'(STUFF_LIMIT)) && !bit_val;
        stuff_err  = sym_ok && (ones == 3'(STUFF_LIMIT)) && bit_val;
        shifted    = {bit_val, shreg[DATA_BITS-1:1]};
        fail       = 1'b0;
        if (sample) begin
            case (state)
                IDLE: fail = (line == SE1);
                SYNC: fail = !sym_ok || stuff_err ||
                             (!stuff_drop && cnt == 7'd7 &&
                              shifted[DATA_BITS-1 -: 8] != SYNC_BITS);
                DATA: fail = (line == SE1) || stuff_err ||
                             (line == SE0 && cnt != 7'(DATA_BITS)) ||
                             (sym_ok && !stuff_drop && cnt == 7'(DATA_BITS));
                EOP:  fail = eop_stage ? (line != J) : (line != SE0);
                default: fail = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rcv_data       <= '0;
            rcv_data_valid <= 1'b0;
            rcv_error      <= 1'b0;
            receiving      <= 1'b0;
            nrzi_ref       <= J;
            ones           <= '0;
            cnt            <= '0;
            eop_stage      <= 1'b0;
            shreg          <= '0;
        end else begin
            rcv_data_valid <= 1'b0;
            rcv_error      <= 1'b0;
            if (fail) begin
                state     <= ERROR;
                rcv_error <= 1'b1;
                receiving <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        nrzi_ref  <= J;
                        ones      <= '0;
                        cnt       <= '0;
                        eop_stage <= 1'b0;
                        if (jk_edge) begin
                            state     <= SYNC;
                            receiving <= 1'b1;
                        end
                    end
                    SYNC, DATA: begin
                        if (sample) begin
                            if (sym_ok)
                                nrzi_ref <= line;
                            if (line == SE0) begin
                                state <= EOP;
                            end else if (stuff_drop) begin
                                ones <= '0;
                            end else begin
                                ones  <= bit_val ? ones + 3'd1 : 3'd0;
                                shreg <= shifted;
                                if (state == SYNC && cnt == 7'd7) begin
                                    state <= DATA;
                                    cnt   <= '0;
                                end else begin
                                    cnt <= cnt + 7'd1;
                                end
                            end
                        end
                    end
                    EOP: begin
                        if (sample) begin
                            if (eop_stage) begin
                                state          <= DONE;
                                rcv_data       <= shreg;
                                rcv_data_valid <= 1'b1;
                            end else begin
                                eop_stage <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        receiving <= 1'b0;
                    end
                    ERROR: begin
                        if (sample) begin
                            if (line != J)
                                cnt <= '0;
                            else if (cnt == 7'(IDLE_BITS - 1)) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else
                                cnt <= cnt + 7'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_receiver.sv
// Directed bench for usb_receiver: a behavioural transmitter builds line symbols for each packet.
module tb_usb_receiver;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    localparam logic [63:0] PL_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PL_B = 64'hDEAD_BEEF_0F1E_2D3C;
    localparam logic [63:0] PL_C = 64'hA5C3_0FF0_1234_8001;
    localparam logic [63:0] PL_F = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_plus;
    logic        d_minus;
    logic [63:0] rcv_data;
    logic        rcv_data_valid;
    logic        rcv_error;
    logic        receiving;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_rx = 0;

    logic [1:0] sym_q[$];

    usb_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .rcv_data      (rcv_data),
        .rcv_data_valid(rcv_data_valid),
        .rcv_error     (rcv_error),
        .receiving     (receiving)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rcv_data_valid) n_valid++;
        if (rcv_error)      n_err++;
        if (receiving)      n_rx++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // NRZI-encode SYNC + payload with bit stuffing; optional corrupted stuff bit, SE0-SE0-J EOP, idle J.
    task automatic build(input logic [64:0] pl, input int nbits, input int corrupt,
                         input bit eop, input bit bad_sync);
        logic [1:0] lvl;
        logic       b;
        int         ones;
        int         stuffed;
        sym_q.delete();
        lvl     = LJ;
        ones    = 0;
        stuffed = 0;
        for (int i = 0; i < 8 + nbits; i++) begin
            b = (i < 8) ? ((i == 7) && !bad_sync) : pl[i-8];
            if (!b) lvl = (lvl == LJ) ? LK : LJ;
            sym_q.push_back(lvl);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                if (stuffed != corrupt) lvl = (lvl == LJ) ? LK : LJ;
                sym_q.push_back(lvl);
                ones = 0;
                stuffed++;
            end
        end
        if (eop) begin
            sym_q.push_back(LSE0);
            sym_q.push_back(LSE0);
            sym_q.push_back(LJ);
        end
        for (int i = 0; i < 12; i++) sym_q.push_back(LJ);
    endtask

    task automatic idle_bits(input int n);
        {d_plus, d_minus} = LJ;
        repeat (n * 8) @(negedge clk);
    endtask

    task automatic drive(input bit drift, input int abort_at);
        int per;
        for (int i = 0; i < sym_q.size(); i++) begin
            if (i == abort_at) begin
                {d_plus, d_minus} = LJ;
                rst = 1'b1;
                #1;
                chk("rst.data",      rcv_data, 64'h0);
                chk("rst.valid",     64'(rcv_data_valid), 64'h0);
                chk("rst.error",     64'(rcv_error), 64'h0);
                chk("rst.receiving", 64'(receiving), 64'h0);
                repeat (4) @(negedge clk);
                rst = 1'b0;
                idle_bits(12);
                return;
            end
            {d_plus, d_minus} = sym_q[i];
            per = drift ? ((i % 2) ? 9 : 7) : 8;
            repeat (per) @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [64:0] pl, input int nbits,
                       input int corrupt, input bit eop, input bit bad_sync,
                       input bit drift, input int abort_at,
                       input int exp_v, input int exp_e, input logic [63:0] exp_data);
        int v0;
        int e0;
        int r0;
        v0 = n_valid;
        e0 = n_err;
        r0 = n_rx;
        build(pl, nbits, corrupt, eop, bad_sync);
        drive(drift, abort_at);
        chk({tag, ".valid"}, 64'(n_valid - v0), 64'(exp_v));
        chk({tag, ".error"}, 64'(n_err - e0), 64'(exp_e));
        chk({tag, ".data"},  rcv_data, exp_data);
        if (exp_v == 1)
            chk({tag, ".rx_seen"}, 64'(n_rx - r0 > 0), 64'h1);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        {d_plus, d_minus} = LJ;
        repeat (3) @(negedge clk);
        chk("reset.data",      rcv_data, 64'h0);
        chk("reset.valid",     64'(rcv_data_valid), 64'h0);
        chk("reset.error",     64'(rcv_error), 64'h0);
        chk("reset.receiving", 64'(receiving), 64'h0);
        rst = 1'b0;
        idle_bits(4);

        run("good_a",      {1'b0, PL_A}, 64, -1, 1, 0, 0, -1, 1, 0, PL_A);
        run("stuff_ones",  {1'b0, PL_F}, 64, -1, 1, 0, 0, -1, 1, 0, PL_F);
        run("stuff_bad",   {1'b0, PL_F}, 64,  0, 1, 0, 0, -1, 0, 1, PL_F);
        run("bad_sync",    65'h0,         0, -1, 0, 1, 0, -1, 0, 1, PL_F);
        run("after_sync",  {1'b0, PL_B}, 64, -1, 1, 0, 0, -1, 1, 0, PL_B);
        run("short63",     {1'b0, PL_A}, 63, -1, 1, 0, 0, -1, 0, 1, PL_B);
        run("long65",      {1'b0, PL_A}, 65, -1, 0, 0, 0, -1, 0, 1, PL_B);
        run("drift",       {1'b0, PL_C}, 64, -1, 1, 0, 1, -1, 1, 0, PL_C);
        run("abort",       {1'b0, PL_A}, 64, -1, 1, 0, 0, 38, 0, 0, 64'h0);
        run("after_rst",   {1'b0, PL_A}, 64, -1, 1, 0, 0, -1, 1, 0, PL_A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
